// File: rtl/spi_master_sched_pkg.sv
// Shared types and constants for the round-robin SPI master scheduler.
package spi_pkg;
  localparam int SPI_XFER_BITS = 32;
  localparam int BIT_CNT_W     = $clog2(SPI_XFER_BITS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_e;
endpackage

// File: rtl/spi_master_sched_if.sv
// Requester-side handshake plus SPI pins; master = scheduler, slave = requesters/bus partner.
interface spi_master_sched_if #(
  parameter int NUM_REQ = 2
);
  import spi_pkg::*;

  logic [NUM_REQ-1:0]               req;
  logic [NUM_REQ*SPI_XFER_BITS-1:0] tx_data;
  logic [NUM_REQ-1:0]               grant;
  logic                             busy;
  logic                             done;
  logic [SPI_XFER_BITS-1:0]         rx_data;
  logic                             SCLK;
  logic                             CS;
  logic                             MOSI;
  logic                             MISO;

  modport master (
    input  req, tx_data, MISO,
    output grant, busy, done, rx_data, SCLK, CS, MOSI
  );

  modport slave (
    output req, tx_data, MISO,
    input  grant, busy, done, rx_data, SCLK, CS, MOSI
  );
endinterface

// File: rtl/spi_rr_arbiter.sv
// Round-robin one-hot pick; the search pointer moves past the winner on accept.
module spi_rr_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               accept,
  output logic [NUM_REQ-1:0] pick,
  output logic [IDX_W-1:0]   win_idx
);
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             found;

  always_comb begin
    int idx;
    idx     = 0;
    pick    = '0;
    win_idx = '0;
    found   = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = (int'(ptr_q) + off) % NUM_REQ;
      if (!found && req[idx]) begin
        found        = 1'b1;
        pick[idx]    = 1'b1;
        win_idx      = IDX_W'(idx);
      end
    end
    ptr_d = ptr_q;
    if (accept) ptr_d = IDX_W'((int'(win_idx) + 1) % NUM_REQ);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
endmodule

// File: rtl/spi_master_sched.sv
// SPI master scheduler: grants one requester at a time and runs a 32-bit mode-0 transfer.
//   state | meaning
//   IDLE  | waiting for any req; accept latches winner and drops CS
//   SETUP | CS low, SCLK low, CS_SETUP cycles before first rise
//   SHIFT | 32 SCLK periods, sample MISO one clk after each rise
//   HOLD  | CS low after last fall, then done pulse and rx_data update
//   GAP   | CS high recovery, grant cleared, requests ignored
module spi_master_sched
  import spi_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int GAP      = 4
) (
  input logic               clk,
  input logic               reset,
  spi_master_sched_if.master bus
);
  localparam int CNT_W = 16;
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [BIT_CNT_W-1:0]     bit_q, bit_d;
  logic [SPI_XFER_BITS-2:0] tx_sh_q, tx_sh_d;
  logic [SPI_XFER_BITS-1:0] rx_sh_q, rx_sh_d;
  logic [SPI_XFER_BITS-1:0] rx_data_q, rx_data_d;
  logic [NUM_REQ-1:0]       grant_q, grant_d;
  logic                     sclk_q, sclk_d, cs_q, cs_d, mosi_q, mosi_d;
  logic                     busy_q, busy_d, done_q, done_d;
  logic                     accept;
  logic [NUM_REQ-1:0]       pick;
  logic [IDX_W-1:0]         win_idx;
  logic [SPI_XFER_BITS-1:0] tx_word;

  assign tx_word = bus.tx_data[SPI_XFER_BITS*int'(win_idx) +: SPI_XFER_BITS];

  spi_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (bus.req),
    .accept  (accept),
    .pick    (pick),
    .win_idx (win_idx)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    grant_d   = grant_q;
    sclk_d    = sclk_q;
    cs_d      = cs_q;
    mosi_d    = mosi_q;
    done_d    = 1'b0;
    accept    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|bus.req) begin
          accept  = 1'b1;
          grant_d = pick;
          mosi_d  = tx_word[SPI_XFER_BITS-1];
          tx_sh_d = tx_word[SPI_XFER_BITS-2:0];
          cs_d    = 1'b0;
          bit_d   = '0;
          cnt_d   = CNT_W'(CS_SETUP - 1);
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          sclk_d  = 1'b1;
          cnt_d   = CNT_W'(CLK_DIV - 1);
          state_d = ST_SHIFT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_SHIFT: begin
        if (sclk_q) begin
          // first clk after the rise: MOSI/MISO have settled for a full half-period
          if (cnt_q == CNT_W'(CLK_DIV - 1)) rx_sh_d = {rx_sh_q[SPI_XFER_BITS-2:0], bus.MISO};
          if (cnt_q == '0) begin
            sclk_d  = 1'b0;
            mosi_d  = tx_sh_q[SPI_XFER_BITS-2];
            tx_sh_d = {tx_sh_q[SPI_XFER_BITS-3:0], 1'b0};
            cnt_d   = CNT_W'(CLK_DIV - 1);
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end else if (cnt_q == '0) begin
          if (bit_q == BIT_CNT_W'(SPI_XFER_BITS - 1)) begin
            cnt_d   = CNT_W'(CS_HOLD);
            state_d = ST_HOLD;
          end else begin
            sclk_d = 1'b1;
            bit_d  = bit_q + BIT_CNT_W'(1);
            cnt_d  = CNT_W'(CLK_DIV - 1);
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          cs_d      = 1'b1;
          rx_data_d = rx_sh_q;
          done_d    = 1'b1;
          cnt_d     = CNT_W'(GAP - 1);
          state_d   = ST_GAP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_GAP: begin
        grant_d = '0;
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      grant_q   <= '0;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b1;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      grant_q   <= grant_d;
      sclk_q    <= sclk_d;
      cs_q      <= cs_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.grant   = grant_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rx_data = rx_data_q;
  assign bus.SCLK    = sclk_q;
  assign bus.CS      = cs_q;
  assign bus.MOSI    = mosi_q;
endmodule

// File: tb/tb_spi_master_sched.sv
// Randomized bench for spi_master_sched with a transfer-level reference model and MISO responder.
module tb_spi_master_sched;
  localparam int N       = 2;
  localparam int GAP_C   = 4;
  localparam int LAT     = 1 + 2 + 64*4 + 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  spi_master_sched_if #(.NUM_REQ(N)) bus ();

  spi_master_sched #(
    .NUM_REQ(N), .CLK_DIV(4), .CS_SETUP(2), .CS_HOLD(2), .GAP(GAP_C)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // monitor / responder state
  logic        loopback = 1'b1;
  logic [31:0] miso_word = '0;
  int          miso_idx = -1;
  logic        prev_cs = 1'b1, prev_sclk = 1'b0;
  int          cs_falls = 0, done_cnt = 0, rises = 0;
  int          accept_cyc = 0, cs_high_len = 0, last_gap = 0;
  logic [31:0] mosi_bits = '0;
  logic [1:0]  acc_grant = '0;

  // reference model state
  int          ptr_m = 0;
  int          done_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int rr_pick(input int ptr, input logic [1:0] mask);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (ptr + k) % N;
      if (mask[i]) return i;
    end
    return -1;
  endfunction

  initial begin
    bus.MISO = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_cs && !bus.CS) begin
        cs_falls++;
        accept_cyc = cyc;
        acc_grant  = bus.grant;
        rises      = 0;
        mosi_bits  = '0;
        last_gap   = cs_high_len;
        miso_idx   = 31;
      end
      if (bus.CS) cs_high_len++;
      else        cs_high_len = 0;
      if (!prev_sclk && bus.SCLK) begin
        mosi_bits = {mosi_bits[30:0], bus.MOSI};
        rises++;
      end
      if (prev_sclk && !bus.SCLK) miso_idx--;
      if (bus.done) done_cnt++;
      prev_cs   = bus.CS;
      prev_sclk = bus.SCLK;
      bus.MISO  = loopback ? bus.MOSI : ((miso_idx >= 0) ? miso_word[miso_idx] : 1'b0);
    end
  end

  task automatic wait_busy();
    int t;
    t = 0;
    while (!bus.busy && t < 600) begin
      @(negedge clk);
      t++;
    end
    if (!bus.busy) chk("accept_timeout", 32'd0, 32'd1);
    #1;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    @(negedge clk);
    while (!bus.done && t < 600) begin
      @(negedge clk);
      t++;
    end
    if (!bus.done) chk("done_timeout", 32'd0, 32'd1);
    done_cyc = cyc;
    #1;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (bus.busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (bus.busy) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_xfer(input string tag, input int w, input logic [31:0] exp_tx,
                            input logic [31:0] exp_rx);
    logic [1:0] g;
    g = 2'(1 << w);
    chk({tag, "_grant"}, 32'(acc_grant), 32'(g));
    chk({tag, "_grant_at_done"}, 32'(bus.grant), 32'(g));
    chk({tag, "_mosi"}, mosi_bits, exp_tx);
    chk({tag, "_rises"}, rises, 32);
    chk({tag, "_rx"}, bus.rx_data, exp_rx);
    chk({tag, "_latency"}, done_cyc - accept_cyc, LAT);
  endtask

  initial begin
    logic [31:0] words [N];
    logic [31:0] exp_tx;
    logic [1:0]  mask;
    int          w, req_cyc, prev_done, base, t;

    reset = 1'b1;
    bus.req = '0;
    bus.tx_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_cs", 32'(bus.CS), 1);
    chk("rst_sclk", 32'(bus.SCLK), 0);
    chk("rst_mosi", 32'(bus.MOSI), 0);
    chk("rst_grant", 32'(bus.grant), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_rx", bus.rx_data, 0);
    reset = 1'b0;
    @(negedge clk);

    // directed loopback word
    loopback = 1'b1;
    bus.tx_data = {$urandom, 32'hA5A50F0F};
    req_cyc = cyc;
    bus.req = 2'b01;
    w = rr_pick(ptr_m, 2'b01);
    ptr_m = (w + 1) % N;
    wait_busy();
    chk("accept_latency", accept_cyc - req_cyc, 1);
    wait_done();
    check_xfer("loop", w, 32'hA5A50F0F, 32'hA5A50F0F);
    bus.req = '0;
    wait_idle();

    // random masks, random words, tx_data scrambled after accept
    loopback = 1'b0;
    for (int it = 0; it < 6; it++) begin
      mask = 2'($urandom_range(1, 3));
      for (int i = 0; i < N; i++) words[i] = $urandom;
      miso_word = $urandom;
      bus.tx_data = {words[1], words[0]};
      w = rr_pick(ptr_m, mask);
      ptr_m = (w + 1) % N;
      exp_tx = words[w];
      bus.req = mask;
      wait_busy();
      repeat ($urandom_range(5, 120)) @(negedge clk);
      bus.tx_data = {$urandom, $urandom};
      wait_done();
      check_xfer("rand", w, exp_tx, miso_word);
      bus.req = '0;
      wait_idle();
    end

    // both held for four back-to-back transfers
    for (int i = 0; i < N; i++) words[i] = $urandom;
    bus.tx_data = {words[1], words[0]};
    miso_word = $urandom;
    bus.req = 2'b11;
    prev_done = -1;
    for (int k = 0; k < 4; k++) begin
      w = rr_pick(ptr_m, 2'b11);
      ptr_m = (w + 1) % N;
      wait_done();
      check_xfer("b2b", w, words[w], miso_word);
      if (prev_done >= 0) begin
        chk("b2b_accept_gap", accept_cyc - prev_done, GAP_C + 1);
        chk("b2b_cs_high_min", 32'(last_gap >= GAP_C), 1);
      end
      prev_done = done_cyc;
      miso_word = $urandom;
    end
    bus.req = '0;
    wait_idle();

    // requester 1 drops req at bit 5: transfer completes, no retry
    words[1] = $urandom;
    bus.tx_data = {words[1], $urandom};
    miso_word = $urandom;
    bus.req = 2'b10;
    w = rr_pick(ptr_m, 2'b10);
    ptr_m = (w + 1) % N;
    wait_busy();
    t = 0;
    while (rises < 6 && t < 200) begin
      @(negedge clk);
      t++;
    end
    bus.req = '0;
    wait_done();
    check_xfer("drop", w, words[1], miso_word);
    @(negedge clk);
    chk("drop_grant_clear", 32'(bus.grant), 0);
    base = cs_falls;
    repeat (300) @(negedge clk);
    chk("drop_no_retry", cs_falls, base);
    chk("drop_idle", 32'(bus.busy), 0);

    // reset during bit 10
    loopback = 1'b1;
    words[0] = $urandom;
    bus.tx_data = {$urandom, words[0]};
    bus.req = 2'b01;
    w = rr_pick(ptr_m, 2'b01);
    ptr_m = (w + 1) % N;
    wait_busy();
    t = 0;
    while (rises < 11 && t < 300) begin
      @(negedge clk);
      t++;
    end
    base = done_cnt;
    #3 reset = 1'b1;
    bus.req = 2'b11;
    #1;
    chk("rst_mid_cs", 32'(bus.CS), 1);
    chk("rst_mid_sclk", 32'(bus.SCLK), 0);
    repeat (3) @(negedge clk);
    chk("rst_mid_no_done", done_cnt, base);
    ptr_m = 0;
    w = rr_pick(ptr_m, 2'b11);
    ptr_m = (w + 1) % N;
    reset = 1'b0;
    wait_done();
    check_xfer("post_rst", w, words[0], words[0]);
    chk("post_rst_done_cnt", done_cnt, base + 1);
    bus.req = '0;
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_master_sched.md
# spi_master_sched

Round-robin SPI master scheduler for the 32-bit SPI link. Arbitrates between `NUM_REQ` on-chip requesters, owns the SPI bus pins (SCLK, CS, MOSI, MISO), and runs one full 32-bit transfer per grant. The mode matches the 32-bit SPI slave: SCLK idles low, MOSI is stable across each rising edge, and the slave updates MISO after each falling edge. It sits between the system-side requesters and the external or loopback SPI slave.

## Interface
- `NUM_REQ`, 2: number of requesters (≥1).
- `CLK_DIV`, 4: SCLK half-period in clk cycles (≥2, so the slave's edge detector sees every edge).
- `CS_SETUP`, 2: clk cycles CS is low before the first SCLK rise (≥2).
- `CS_HOLD`, 2: clk cycles CS stays low after the last SCLK fall (≥1).
- `GAP`, 4: minimum clk cycles CS is high between transfers (≥2, covers the slave's DONE state).

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high.
- `req` in NUM_REQ: per-requester transfer request, level; held until `done` with own grant.
- `tx_data` in NUM_REQ*32: flat tx words; requester i uses bits [32i+31:32i].
- `grant` out NUM_REQ: one-hot, high from accept until the `done` cycle inclusive.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse at end of transfer.
- `rx_data` out 32: received word; valid from `done` until the next `done`.
- `SCLK` out 1, `CS` out 1 (active low), `MOSI` out 1, `MISO` in 1: SPI bus.

## Operation
- States: IDLE, SETUP, SHIFT, HOLD, GAP.
- IDLE: if any `req` is high, the round-robin pick is registered into `grant`. `tx_data` of the winner is latched into the tx shifter. CS goes low, MOSI = bit 31, then go to SETUP.
- Round-robin: search starts at the index after the last granted requester and wraps. The pointer resets to requester 0 (first search starts at 0).
- SETUP: count CS_SETUP cycles with SCLK low, then go to SHIFT.
- SHIFT: 32 bit periods of 2*CLK_DIV cycles each; SCLK is high for the first CLK_DIV cycles, then low for CLK_DIV.
  - MISO is sampled into the rx shifter LSB (shift left) at the clk edge one cycle after SCLK rises.
  - MOSI advances to the next lower bit at the same clk edge that drives SCLK low. After bit 0 it holds 0.
  - A 5-bit bit counter ends SHIFT after the 32nd low half, then go to HOLD.
- HOLD: CS_HOLD cycles, CS low, SCLK low. On exit: CS high, `rx_data` ← rx shifter, `done` = 1, grant cleared in the following cycle, then go to GAP.
- GAP: GAP cycles with CS high, then go to IDLE. Requests are not evaluated during GAP.
- MSB first on both MOSI and MISO.
- `req` deassertion mid-transfer is ignored; the transfer completes. A requester that drops `req` before `done` gets no retry.
- Changes to `tx_data` after accept have no effect.

## Timing
- Reset values: SCLK=0, CS=1, MOSI=0, grant=0, busy=0, done=0, rx_data=0, state IDLE, RR pointer=0.
- Reset mid-transfer: CS returns high and SCLK low asynchronously. The partial transfer is discarded and `done` is not pulsed.
- All outputs are registered; no combinational path from `req`/MISO to the pins.
- Latency: `req` high at edge N → grant/CS low/busy visible after edge N+1.
- First SCLK rise is CS_SETUP cycles after CS falls.
- `done` occurs 1 + CS_SETUP + 64*CLK_DIV + CS_HOLD cycles after the accept edge. For defaults this is 261 cycles.
- Back-to-back: earliest next accept is GAP+1 cycles after `done`.
- Simultaneous requests: exactly one grant per transfer; never two grant bits high.

## Structure
- Package `spi_pkg`:
  - state enum (IDLE, SETUP, SHIFT, HOLD, GAP);
  - `SPI_XFER_BITS` = 32;
  - bit-counter width constant.
- Sub-module `spi_rr_arbiter` (NUM_REQ): combinational one-hot pick from `req` and the pointer, plus the registered pointer update on accept.
- Top holds the FSM, clock divider counter, bit counter, and tx/rx shifters.

## Test plan
- Single req0, tx 0xA5A50F0F, MISO looped to MOSI:
  - MOSI sequence 1,0,1,0,0,1,0,1,… across the 32 rising edges;
  - rx_data = 0xA5A50F0F at `done`;
  - `done` exactly 261 cycles after accept.
- Attach the 32-bit SPI slave (same clk, `data_in`=0x12345678), master tx 0xDEADBEEF, CLK_DIV=2:
  - slave `data_out` = 0xDEADBEEF;
  - master rx_data = 0x12345678 (master captures the slave's MISO stream, which is the slave's `data_in` shifted per its falling-edge update).
- req0 and req1 both held high for 4 transfers: grant order 0,1,0,1; CS high for ≥GAP cycles between transfers.
- Reset asserted during bit 10:
  - CS=1 and SCLK=0 immediately;
  - no `done`;
  - next transfer after reset grants requester 0 with full 32 bits.
- req1 dropped at bit 5 of its transfer: transfer completes, `done` pulses, grant[1] clears, no retransfer.
- `tx_data` changed mid-transfer: MOSI stream still reflects the word latched at accept.
